multicycle_control_unit: RTL and testbench

Multi-cycle control FSM for the RISC core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives ALU, register-file, memory and PC controls. It extends the single-cycle opcode decoder with a wider parametrised opcode field, XOR/LOAD/STORE/BEQ/JMP/HALT, a memory ready handshake and illegal-opcode detection. It sits between the instruction register and the datapath.

---
 rtl/multicycle_control_unit.sv | 267 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle control FSM for the RISC core. Each instruction is walked
// through FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK) and the unit
// drives the ALU, register-file, memory and PC controls of the datapath.
// A HALT opcode parks the core in HALT until reset; any opcode outside the
// defined set is executed as a NOP and raises a sticky illegal_op flag.
//
// Optional feature macro: CU_PERF_CNT_EN
//   When defined, a 16-bit retired_cnt output counts the cycles in which
//   pc_en is asserted (one per retired instruction), wrapping at 16'hFFFF.
//
// Parameters:
//   OPCODE_W   opcode field width (>= 4); set bits above bit 3 => illegal
//   ALU_SEL_W  ALU select width (ADD=0 SUB=1 AND=2 OR=3 XOR=4)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   opcode       in   opcode from the instruction register (valid in DECODE)
//   zero_flag    in   ALU zero result, used by BEQ in EXECUTE
//   mem_ready    in   memory completes the current read/write this cycle
//   mem_read     out  memory read request (instruction fetch or LOAD)
//   mem_write    out  memory write request (STORE)
//   ir_load      out  load instruction register
//   alu_sel      out  ALU operation
//   alu_src_imm  out  ALU operand B = immediate
//   reg_write    out  register-file write enable
//   wb_sel       out  writeback source: 0 = ALU, 1 = memory
//   pc_en        out  PC update enable
//   pc_sel       out  next PC: 0 = PC+1, 1 = target
//   halted       out  core halted
//   illegal_op   out  sticky illegal-opcode flag
//   retired_cnt  out  retired-instruction counter (CU_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
   parameter int OPCODE_W  = 4,
   parameter int ALU_SEL_W = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [OPCODE_W-1:0]  opcode,
   input  logic                 zero_flag,
   input  logic                 mem_ready,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 ir_load,
   output logic [ALU_SEL_W-1:0] alu_sel,
   output logic                 alu_src_imm,
   output logic                 reg_write,
   output logic                 wb_sel,
   output logic                 pc_en,
   output logic                 pc_sel,
   output logic                 halted,
   output logic                 illegal_op
`ifdef CU_PERF_CNT_EN
   ,
   output logic [15:0]          retired_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WRITEBACK,
      S_HALT
   } state_t;

   // Opcodes are compared on the low nibble only after the upper bits have
   // been confirmed zero by op_legal().
   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_LOAD  = 4'd5;
   localparam logic [3:0] OP_STORE = 4'd6;
   localparam logic [3:0] OP_BEQ   = 4'd7;
   localparam logic [3:0] OP_JMP   = 4'd8;
   localparam logic [3:0] OP_HALT  = 4'd15;

   localparam logic [ALU_SEL_W-1:0] ALU_ADD = ALU_SEL_W'(0);
   localparam logic [ALU_SEL_W-1:0] ALU_SUB = ALU_SEL_W'(1);
   localparam logic [ALU_SEL_W-1:0] ALU_AND = ALU_SEL_W'(2);
   localparam logic [ALU_SEL_W-1:0] ALU_OR  = ALU_SEL_W'(3);
   localparam logic [ALU_SEL_W-1:0] ALU_XOR = ALU_SEL_W'(4);

   state_t              state;
   state_t              state_next;
   logic [OPCODE_W-1:0] op_q;

   // Legal opcodes: 0..8 and 15, with every bit above bit 3 clear.
   function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
      logic [OPCODE_W-1:0] upper;
      upper = op >> 4;
      if (upper != '0) begin
         return 1'b0;
      end
      return (op[3:0] <= OP_JMP) || (op[3:0] == OP_HALT);
   endfunction

   // State, latched opcode and sticky illegal flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         op_q       <= '0;
         illegal_op <= 1'b0;
      end else begin
         state <= state_next;
         if (state == S_DECODE) begin
            op_q <= opcode;
            if (!op_legal(opcode)) begin
               illegal_op <= 1'b1;
            end
         end
      end
   end

   // Next-state and output decode
   always_comb begin
      state_next  = state;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_load     = 1'b0;
      alu_sel     = ALU_ADD;
      alu_src_imm = 1'b0;
      reg_write   = 1'b0;
      wb_sel      = 1'b0;
      pc_en       = 1'b0;
      pc_sel      = 1'b0;
      halted      = 1'b0;

      case (state)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_load    = 1'b1;
               state_next = S_DECODE;
            end
         end

         S_DECODE: begin
            if (op_legal(opcode) && (opcode[3:0] == OP_HALT)) begin
               state_next = S_HALT;
            end else begin
               state_next = S_EXECUTE;
            end
         end

         S_EXECUTE: begin
            if (!op_legal(op_q)) begin
               // Illegal opcode retires as a NOP: step the PC, touch nothing.
               pc_en      = 1'b1;
               state_next = S_FETCH;
            end else begin
               case (op_q[3:0])
                  OP_ADD: begin
                     alu_sel    = ALU_ADD;
                     state_next = S_WRITEBACK;
                  end
                  OP_SUB: begin
                     alu_sel    = ALU_SUB;
                     state_next = S_WRITEBACK;
                  end
                  OP_AND: begin
                     alu_sel    = ALU_AND;
                     state_next = S_WRITEBACK;
                  end
                  OP_OR: begin
                     alu_sel    = ALU_OR;
                     state_next = S_WRITEBACK;
                  end
                  OP_XOR: begin
                     alu_sel    = ALU_XOR;
                     state_next = S_WRITEBACK;
                  end
                  OP_LOAD, OP_STORE: begin
                     // Address = base + immediate
                     alu_sel     = ALU_ADD;
                     alu_src_imm = 1'b1;
                     state_next  = S_MEM;
                  end
                  OP_BEQ: begin
                     alu_sel    = ALU_SUB;
                     pc_en      = 1'b1;
                     pc_sel     = zero_flag;
                     state_next = S_FETCH;
                  end
                  OP_JMP: begin
                     pc_en      = 1'b1;
                     pc_sel     = 1'b1;
                     state_next = S_FETCH;
                  end
                  default: begin
                     // HALT never reaches EXECUTE; treat defensively as NOP.
                     pc_en      = 1'b1;
                     state_next = S_FETCH;
                  end
               endcase
            end
         end

         S_MEM: begin
            // Address stays on the ALU for the whole access, including waits.
            alu_sel     = ALU_ADD;
            alu_src_imm = 1'b1;
            if (op_q[3:0] == OP_LOAD) begin
               mem_read = 1'b1;
               if (mem_ready) begin
                  state_next = S_WRITEBACK;
               end
            end else begin
               mem_write = 1'b1;
               if (mem_ready) begin
                  pc_en      = 1'b1;
                  state_next = S_FETCH;
               end
            end
         end

         S_WRITEBACK: begin
            reg_write  = 1'b1;
            pc_en      = 1'b1;
            wb_sel     = (op_q[3:0] == OP_LOAD);
            state_next = S_FETCH;
         end

         S_HALT: begin
            halted = 1'b1;
         end

         default: begin
            state_next = S_FETCH;
         end
      endcase

      // The state register resets to FETCH, whose decode would request a
      // fetch; suppress every output while reset is held.
      if (!rst_n) begin
         mem_read    = 1'b0;
         mem_write   = 1'b0;
         ir_load     = 1'b0;
         alu_sel     = ALU_ADD;
         alu_src_imm = 1'b0;
         reg_write   = 1'b0;
         wb_sel      = 1'b0;
         pc_en       = 1'b0;
         pc_sel      = 1'b0;
         halted      = 1'b0;
      end
   end

`ifdef CU_PERF_CNT_EN
   // One pc_en pulse per retired instruction; wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= '0;
      end else if (pc_en) begin
         retired_cnt <= retired_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed bench for multicycle_control_unit. A per-instruction model builds
// the expected output vector for every cycle from the instruction rules; one
// compare process checks the DUT against it on each falling edge. Literal
// latency / flag checks pin the model itself.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

   localparam int OW = 4;
   localparam int AW = 3;

   logic          clk;
   logic          rst_n;
   logic [OW-1:0] opcode;
   logic          zero_flag;
   logic          mem_ready;
   logic          mem_read;
   logic          mem_write;
   logic          ir_load;
   logic [AW-1:0] alu_sel;
   logic          alu_src_imm;
   logic          reg_write;
   logic          wb_sel;
   logic          pc_en;
   logic          pc_sel;
   logic          halted;
   logic          illegal_op;
`ifdef CU_PERF_CNT_EN
   logic [15:0]   retired_cnt;
   logic [15:0]   exp_cnt;
   int            cnt_model;
`endif

   int          checks   = 0;
   int          failures = 0;
   logic        chk_en   = 1'b0;
   logic [12:0] exp_vec;
   logic [12:0] dut_vec;
   logic        ill_model;
   int          step_cnt;
   int          pc_en_seen = 0;

   multicycle_control_unit #(
      .OPCODE_W  (OW),
      .ALU_SEL_W (AW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .zero_flag   (zero_flag),
      .mem_ready   (mem_ready),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .ir_load     (ir_load),
      .alu_sel     (alu_sel),
      .alu_src_imm (alu_src_imm),
      .reg_write   (reg_write),
      .wb_sel      (wb_sel),
      .pc_en       (pc_en),
      .pc_sel      (pc_sel),
      .halted      (halted),
      .illegal_op  (illegal_op)
`ifdef CU_PERF_CNT_EN
      ,
      .retired_cnt (retired_cnt)
`endif
   );

   assign dut_vec = {mem_read, mem_write, ir_load, alu_sel, alu_src_imm,
                     reg_write, wb_sel, pc_en, pc_sel, halted, illegal_op};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=0x%0h want=0x%0h at %0t", name, got, want, $time);
      end
   endtask

   // Expected control vector without the illegal_op bit.
   // Bit order: mem_read mem_write ir_load alu_sel[2:0] alu_src_imm
   //            reg_write wb_sel pc_en pc_sel halted
   function automatic logic [11:0] mk(input bit mrd, input bit mwr, input bit irl,
                                      input logic [2:0] alu, input bit imm, input bit rw,
                                      input bit wbs, input bit pe, input bit ps, input bit hl);
      return {mrd, mwr, irl, alu, imm, rw, wbs, pe, ps, hl};
   endfunction

   function automatic bit legal(input int op);
      return (op >= 0 && op <= 8) || op == 15;
   endfunction

   // Compare process: every falling edge while checking is enabled.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("outputs", 32'(dut_vec), 32'(exp_vec));
`ifdef CU_PERF_CNT_EN
         chk("retired_cnt", 32'(retired_cnt), 32'(exp_cnt));
`endif
         if (pc_en === 1'b1) pc_en_seen++;
      end
   end

   // One clock cycle: drive inputs just after the rising edge and publish
   // the outputs the current cycle must show.
   task automatic step(input bit mr, input logic [3:0] opc, input bit zf, input logic [11:0] e);
      @(posedge clk);
      #1;
      mem_ready = mr;
      opcode    = opc;
      zero_flag = zf;
      if (rst_n) begin
         exp_vec = {e, ill_model};
`ifdef CU_PERF_CNT_EN
         exp_cnt = 16'(cnt_model);
         if (e[2]) cnt_model++;
`endif
      end else begin
         exp_vec = '0;
`ifdef CU_PERF_CNT_EN
         exp_cnt = '0;
`endif
      end
      step_cnt++;
   endtask

   task automatic assert_reset();
      #2;
      rst_n     = 1'b0;
      ill_model = 1'b0;
      exp_vec   = '0;
`ifdef CU_PERF_CNT_EN
      cnt_model = 0;
      exp_cnt   = '0;
`endif
      #1;
      chk("outputs_in_reset", 32'(dut_vec), 32'd0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      mem_ready = 1'b0;
      opcode    = 4'h0;
      exp_vec   = {mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0};
`ifdef CU_PERF_CNT_EN
      exp_cnt   = '0;
`endif
      step_cnt++;
      #1;
      chk("fetch_after_release", 32'(mem_read), 32'd1);
   endtask

   // One complete instruction, mem_ready held high except for the stated
   // fetch and memory wait cycles. Returns the number of cycles taken.
   task automatic run(input int op, input bit zf, input int fwait, input int mwait, output int ncyc);
      int         start;
      int         pe0;
      bit         ld;
      logic [3:0] o;
      o     = 4'(op);
      ld    = (op == 5);
      start = step_cnt;
      pe0   = pc_en_seen;
      repeat (fwait) step(1'b0, 4'h0, 1'b0, mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      step(1'b1, 4'h0, 1'b0, mk(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      step(1'b1, o, 1'b0, '0);
      if (!legal(op)) ill_model = 1'b1;
      if (op == 15) begin
         repeat (22) step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                          mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      end else if (!legal(op)) begin
         step(1'b1, o, zf, mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      end else if (op <= 4) begin
         step(1'b1, o, zf, mk(1'b0, 1'b0, 1'b0, 3'(op), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         step(1'b1, o, zf, mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      end else if (op == 5 || op == 6) begin
         step(1'b1, o, zf, mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         repeat (mwait) step(1'b0, o, zf, mk(ld, !ld, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         step(1'b1, o, zf, mk(ld, !ld, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, !ld, 1'b0, 1'b0));
         if (ld) step(1'b1, o, zf, mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
      end else if (op == 7) begin
         step(1'b1, o, zf, mk(1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, zf, 1'b0));
      end else begin
         step(1'b1, o, zf, mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      end
      ncyc = step_cnt - start;
      @(negedge clk);
      #1;
      chk("pc_en_per_instr", 32'(pc_en_seen - pe0), (op == 15) ? 32'd0 : 32'd1);
   endtask

   initial begin
      int n;
      int pe0;
      rst_n     = 1'b1;
      mem_ready = 1'b0;
      opcode    = 4'h0;
      zero_flag = 1'b0;
      ill_model = 1'b0;
      step_cnt  = 0;
      exp_vec   = '0;
`ifdef CU_PERF_CNT_EN
      cnt_model = 0;
      exp_cnt   = '0;
`endif
      #2;
      rst_n  = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("reset_outputs", 32'(dut_vec), 32'd0);
      repeat (2) step(1'b0, 4'h0, 1'b0, '0);
      release_reset();

      // ALU op, LOAD with memory wait, LOAD without wait
      run(0, 1'b0, 0, 0, n);  chk("add_latency", 32'(n), 32'd4);
      run(5, 1'b0, 0, 3, n);  chk("load_wait_latency", 32'(n), 32'd8);
      run(5, 1'b0, 0, 0, n);  chk("load_latency", 32'(n), 32'd5);

      // BEQ taken and not taken
      run(7, 1'b1, 0, 0, n);  chk("beq_taken_latency", 32'(n), 32'd3);
      run(7, 1'b0, 0, 0, n);  chk("beq_not_taken_latency", 32'(n), 32'd3);

      // Remaining ALU ops, STORE, JMP, fetch wait
      run(1, 1'b0, 0, 0, n);
      run(2, 1'b1, 0, 0, n);
      run(3, 1'b0, 0, 0, n);
      run(4, 1'b0, 0, 0, n);
      run(6, 1'b0, 0, 0, n);  chk("store_latency", 32'(n), 32'd4);
      run(6, 1'b0, 1, 2, n);  chk("store_wait_latency", 32'(n), 32'd7);
      run(8, 1'b0, 0, 0, n);  chk("jmp_latency", 32'(n), 32'd3);
      run(0, 1'b0, 2, 0, n);  chk("fetch_wait_latency", 32'(n), 32'd6);
      chk("illegal_clear_before", 32'(illegal_op), 32'd0);

      // Illegal opcodes and stickiness of illegal_op
      run(10, 1'b0, 0, 0, n); chk("illegal_latency", 32'(n), 32'd3);
      run(0, 1'b0, 0, 0, n);
      chk("illegal_sticky", 32'(illegal_op), 32'd1);
      run(9, 1'b0, 0, 0, n);
      run(12, 1'b1, 0, 0, n);
      run(5, 1'b0, 0, 1, n);

      // HALT, held regardless of mem_ready, left only by reset
      run(15, 1'b0, 0, 0, n);
      chk("halted_held", 32'(halted), 32'd1);
      assert_reset();
      chk("halt_cleared", 32'(halted), 32'd0);
      chk("illegal_cleared", 32'(illegal_op), 32'd0);
      repeat (2) step(1'b1, 4'h0, 1'b0, '0);
      release_reset();

      // Reset during the MEM cycle of a STORE aborts the write
      pe0 = pc_en_seen;
      step(1'b1, 4'h0, 1'b0, mk(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      step(1'b1, 4'h6, 1'b0, '0);
      step(1'b1, 4'h6, 1'b0, mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      step(1'b0, 4'h6, 1'b0, mk(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      #1;
      chk("store_mem_write", 32'(mem_write), 32'd1);
      assert_reset();
      chk("store_abort_mem_write", 32'(mem_write), 32'd0);
      repeat (2) step(1'b1, 4'h6, 1'b0, '0);
      release_reset();
      chk("store_abort_no_pc_en", 32'(pc_en_seen - pe0), 32'd0);

      // Three retired instructions after reset
      run(0, 1'b0, 0, 0, n);
      run(6, 1'b0, 0, 0, n);
      run(8, 1'b0, 0, 0, n);
      step(1'b0, 4'h0, 1'b0, mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`ifdef CU_PERF_CNT_EN
      chk("retired_after_three", 32'(retired_cnt), 32'd3);
`endif
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
